// File: rtl/ysyx_23060184_mem_arbiter_if.sv
// Signal bundle around the memory arbiter: IFU and LSU request/response
// channels on one side, the shared memory slave port on the other.
interface ysyx_23060184_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_rsp_valid;
    logic              ifu_rsp_ready;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rsp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic              lsu_rsp_valid;
    logic              lsu_rsp_ready;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_rsp_err;

    logic              s_req_valid;
    logic              s_req_ready;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wen;
    logic [DATA_W-1:0] s_wdata;
    logic [3:0]        s_wmask;
    logic              s_rsp_valid;
    logic              s_rsp_ready;
    logic [DATA_W-1:0] s_rdata;

    // Arbiter view: serves the two CPU masters and masters the memory slave.
    modport master (
        input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
               lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
               s_req_ready, s_rsp_valid, s_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
               lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
               s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_rsp_ready
    );

    // Surrounding view: fetch/load-store stages and the memory model.
    modport slave (
        output ifu_req_valid, ifu_addr, ifu_rsp_ready,
               lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
               s_req_ready, s_rsp_valid, s_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
               lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
               s_req_valid, s_addr, s_wen, s_wdata, s_wmask, s_rsp_ready
    );
endinterface

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter. Round-robin on ties,
// one transaction in flight, per-transaction timeout yielding an error reply.
module ysyx_23060184_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    ysyx_23060184_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] { IDLE, REQ, WAIT, RESP } state_t;
    typedef enum logic { GNT_IFU, GNT_LSU } gnt_t;

    // Budget is spent once the timer sits at TIMEOUT-1 or beyond; using >=
    // also covers a request handshake landing on the expiry cycle, so the
    // following WAIT cycle still times out unless the response arrives.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    gnt_t              gnt;
    gnt_t              last_grant;
    logic [7:0]        timer;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              s_req_valid_q;
    logic              s_rsp_ready_q;
    logic              ifu_rsp_valid_q;
    logic              lsu_rsp_valid_q;

    logic pick_ifu;
    logic pick_lsu;
    logic accept_ifu;
    logic accept_lsu;
    logic expired;
    logic rsp_done;

    // Round-robin pick: a lone requester wins, a tie goes to the one that did not win last.
    always_comb begin
        pick_ifu   = bus.ifu_req_valid && (!bus.lsu_req_valid || last_grant == GNT_LSU);
        pick_lsu   = bus.lsu_req_valid && !pick_ifu;
        accept_ifu = !reset && (state == IDLE) && pick_ifu;
        accept_lsu = !reset && (state == IDLE) && pick_lsu;
        expired    = timer >= TIMER_LAST;
        rsp_done   = (gnt == GNT_IFU) ? bus.ifu_rsp_ready : bus.lsu_rsp_ready;
    end

    // Transaction sequencer: accept, present to slave, collect reply, hand it back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gnt             <= GNT_IFU;
            last_grant      <= GNT_LSU;
            timer           <= '0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            s_req_valid_q   <= 1'b0;
            s_rsp_ready_q   <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_ifu) begin
                        gnt        <= GNT_IFU;
                        last_grant <= GNT_IFU;
                        addr_q     <= bus.ifu_addr;
                        wen_q      <= 1'b0;
                        wdata_q    <= '0;
                        wmask_q    <= '0;
                    end else if (accept_lsu) begin
                        gnt        <= GNT_LSU;
                        last_grant <= GNT_LSU;
                        addr_q     <= bus.lsu_addr;
                        wen_q      <= bus.lsu_wen;
                        wdata_q    <= bus.lsu_wdata;
                        wmask_q    <= bus.lsu_wmask;
                    end
                    if (accept_ifu || accept_lsu) begin
                        timer         <= '0;
                        s_req_valid_q <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    timer <= timer + 8'd1;
                    if (bus.s_req_ready) begin
                        s_req_valid_q <= 1'b0;
                        s_rsp_ready_q <= 1'b1;
                        state         <= WAIT;
                    end else if (expired) begin
                        s_req_valid_q   <= 1'b0;
                        rdata_q         <= '0;
                        err_q           <= 1'b1;
                        ifu_rsp_valid_q <= (gnt == GNT_IFU);
                        lsu_rsp_valid_q <= (gnt == GNT_LSU);
                        state           <= RESP;
                    end
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (bus.s_rsp_valid) begin
                        rdata_q <= wen_q ? '0 : bus.s_rdata;
                        err_q   <= 1'b0;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                    if (bus.s_rsp_valid || expired) begin
                        s_rsp_ready_q   <= 1'b0;
                        ifu_rsp_valid_q <= (gnt == GNT_IFU);
                        lsu_rsp_valid_q <= (gnt == GNT_LSU);
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        ifu_rsp_valid_q <= 1'b0;
                        lsu_rsp_valid_q <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ifu_req_ready = accept_ifu;
    assign bus.lsu_req_ready = accept_lsu;

    assign bus.s_req_valid = s_req_valid_q;
    assign bus.s_rsp_ready = s_rsp_ready_q;
    assign bus.s_addr      = addr_q;
    assign bus.s_wen       = wen_q;
    assign bus.s_wdata     = wdata_q;
    assign bus.s_wmask     = wmask_q;

    // Response fields are gated by the per-master valid so the idle master sees zeros.
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.ifu_rdata     = ifu_rsp_valid_q ? rdata_q : '0;
    assign bus.ifu_rsp_err   = ifu_rsp_valid_q & err_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rdata     = lsu_rsp_valid_q ? rdata_q : '0;
    assign bus.lsu_rsp_err   = lsu_rsp_valid_q & err_q;
endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_ysyx_23060184_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int unsigned n_tests;
    int unsigned n_fail;

    // Model state: who won last, and each master's outstanding request.
    bit          last_lsu;
    bit          pend_ifu;
    bit          pend_lsu;
    logic [31:0] ifu_a;
    logic [31:0] lsu_a;
    logic [31:0] lsu_d;
    bit          lsu_w;
    logic [3:0]  lsu_m;

    ysyx_23060184_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_23060184_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_ifu(input logic [31:0] a);
        pend_ifu = 1'b1;
        ifu_a    = a;
    endtask

    task automatic new_lsu(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] m);
        pend_lsu = 1'b1;
        lsu_a    = a;
        lsu_w    = w;
        lsu_d    = d;
        lsu_m    = m;
    endtask

    // Idle masters wiggle their fields to show only a handshake latches them.
    task automatic drive_masters();
        bus.ifu_req_valid = pend_ifu;
        bus.ifu_addr      = pend_ifu ? ifu_a : $urandom;
        bus.lsu_req_valid = pend_lsu;
        bus.lsu_addr      = pend_lsu ? lsu_a : $urandom;
        bus.lsu_wen       = pend_lsu ? lsu_w : 1'($urandom);
        bus.lsu_wdata     = pend_lsu ? lsu_d : $urandom;
        bus.lsu_wmask     = pend_lsu ? lsu_m : 4'($urandom);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " ifu_req_ready"}, bus.ifu_req_ready, 0);
        check_eq({tag, " ifu_rsp_valid"}, bus.ifu_rsp_valid, 0);
        check_eq({tag, " ifu_rdata"},     bus.ifu_rdata, 0);
        check_eq({tag, " ifu_rsp_err"},   bus.ifu_rsp_err, 0);
        check_eq({tag, " lsu_req_ready"}, bus.lsu_req_ready, 0);
        check_eq({tag, " lsu_rsp_valid"}, bus.lsu_rsp_valid, 0);
        check_eq({tag, " lsu_rdata"},     bus.lsu_rdata, 0);
        check_eq({tag, " lsu_rsp_err"},   bus.lsu_rsp_err, 0);
        check_eq({tag, " s_req_valid"},   bus.s_req_valid, 0);
        check_eq({tag, " s_rsp_ready"},   bus.s_rsp_ready, 0);
        check_eq({tag, " s_addr"},        bus.s_addr, 0);
        check_eq({tag, " s_wen"},         bus.s_wen, 0);
        check_eq({tag, " s_wdata"},       bus.s_wdata, 0);
        check_eq({tag, " s_wmask"},       bus.s_wmask, 0);
    endtask

    task automatic do_reset();
        pend_ifu = 1'b0;
        pend_lsu = 1'b0;
        last_lsu = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        drive_masters();
        bus.s_req_ready   = 1'b0;
        bus.s_rsp_valid   = 1'b0;
        bus.s_rdata       = $urandom;
        bus.ifu_rsp_ready = 1'b0;
        bus.lsu_rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset("reset_held");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset("reset_released");
    endtask

    // One transaction. Slave takes the request dr cycles late and replies dw
    // cycles after that; the granted master holds off rsp_ready for dm cycles.
    // Cycle k counts from the accept (k = 0). abort_k > 0 asserts reset there.
    task automatic run_txn(input int dr, input int dw, input int dm, input int abort_k,
                           input bit rnd, input bit use_rd, input logic [31:0] rd_val);
        int          kr, ks, rs, lim, end_k;
        bit          g_lsu, exp_err, in_rsp, exp_req, exp_srr, ew;
        logic [31:0] ea, ed, erd, sdata;
        logic [3:0]  em;

        @(posedge clk); #1;
        bus.s_req_ready   = 1'b0;
        bus.s_rsp_valid   = 1'b0;
        bus.s_rdata       = $urandom;
        bus.ifu_rsp_ready = 1'($urandom);
        bus.lsu_rsp_ready = 1'($urandom);
        drive_masters();
        @(negedge clk);

        g_lsu = (pend_ifu && pend_lsu) ? !last_lsu : pend_lsu;
        check_eq("accept ifu_req_ready", bus.ifu_req_ready, !g_lsu);
        check_eq("accept lsu_req_ready", bus.lsu_req_ready, g_lsu);
        if (g_lsu) begin
            ea = lsu_a; ew = lsu_w; ed = lsu_d; em = lsu_m;
            pend_lsu = 1'b0;
        end else begin
            ea = ifu_a; ew = 1'b0; ed = '0; em = '0;
            pend_ifu = 1'b0;
        end
        last_lsu = g_lsu;

        // Any cycle at or past TO lacking the handshake it needs ends in an error reply.
        kr = 1 + dr;
        ks = kr + 1 + dw;
        if (kr > TO) begin
            rs = TO + 1;
            exp_err = 1'b1;
        end else begin
            lim = (kr + 1 > TO) ? kr + 1 : TO;
            if (ks <= lim) begin
                rs = ks + 1;
                exp_err = 1'b0;
            end else begin
                rs = lim + 1;
                exp_err = 1'b1;
            end
        end
        end_k = rs + dm;
        sdata = '0;

        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            if (k == abort_k) reset = 1'b1;
            bus.s_req_ready = (k == kr);
            bus.s_rsp_valid = (k == ks);
            bus.s_rdata     = use_rd ? rd_val : $urandom;
            if (k == ks) sdata = bus.s_rdata;
            if (g_lsu) begin
                bus.lsu_rsp_ready = (k == end_k);
                bus.ifu_rsp_ready = 1'($urandom);
            end else begin
                bus.ifu_rsp_ready = (k == end_k);
                bus.lsu_rsp_ready = 1'($urandom);
            end
            if (rnd) begin
                if (!pend_ifu && $urandom_range(0, 5) == 0) new_ifu($urandom);
                if (!pend_lsu && $urandom_range(0, 5) == 0)
                    new_lsu($urandom, 1'($urandom), $urandom, 4'($urandom));
                if (pend_ifu && $urandom_range(0, 15) == 0) pend_ifu = 1'b0;
                if (pend_lsu && $urandom_range(0, 15) == 0) pend_lsu = 1'b0;
            end
            drive_masters();
            @(negedge clk);

            erd     = (exp_err || ew) ? 32'h0 : sdata;
            in_rsp  = (k >= rs);
            exp_req = (k <= kr) && (k < rs);
            exp_srr = (k > kr) && (k <= ks) && (k < rs);
            check_eq($sformatf("c%0d s_req_valid", k), bus.s_req_valid, exp_req);
            check_eq($sformatf("c%0d s_rsp_ready", k), bus.s_rsp_ready, exp_srr);
            check_eq($sformatf("c%0d s_addr", k),      bus.s_addr, ea);
            check_eq($sformatf("c%0d s_wen", k),       bus.s_wen, ew);
            check_eq($sformatf("c%0d s_wdata", k),     bus.s_wdata, ed);
            check_eq($sformatf("c%0d s_wmask", k),     bus.s_wmask, em);
            check_eq($sformatf("c%0d ifu_req_ready", k), bus.ifu_req_ready, 0);
            check_eq($sformatf("c%0d lsu_req_ready", k), bus.lsu_req_ready, 0);
            if (g_lsu) begin
                check_eq($sformatf("c%0d lsu_rsp_valid", k), bus.lsu_rsp_valid, in_rsp);
                if (in_rsp) begin
                    check_eq($sformatf("c%0d lsu_rdata", k),   bus.lsu_rdata, erd);
                    check_eq($sformatf("c%0d lsu_rsp_err", k), bus.lsu_rsp_err, exp_err);
                end
                check_eq($sformatf("c%0d ifu_rsp_valid", k), bus.ifu_rsp_valid, 0);
                check_eq($sformatf("c%0d ifu_rdata", k),     bus.ifu_rdata, 0);
                check_eq($sformatf("c%0d ifu_rsp_err", k),   bus.ifu_rsp_err, 0);
            end else begin
                check_eq($sformatf("c%0d ifu_rsp_valid", k), bus.ifu_rsp_valid, in_rsp);
                if (in_rsp) begin
                    check_eq($sformatf("c%0d ifu_rdata", k),   bus.ifu_rdata, erd);
                    check_eq($sformatf("c%0d ifu_rsp_err", k), bus.ifu_rsp_err, exp_err);
                end
                check_eq($sformatf("c%0d lsu_rsp_valid", k), bus.lsu_rsp_valid, 0);
                check_eq($sformatf("c%0d lsu_rdata", k),     bus.lsu_rdata, 0);
                check_eq($sformatf("c%0d lsu_rsp_err", k),   bus.lsu_rsp_err, 0);
            end

            if (k == abort_k) begin
                pend_ifu = 1'b0;
                pend_lsu = 1'b0;
                last_lsu = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                bus.s_req_ready = 1'b0;
                bus.s_rsp_valid = 1'b0;
                drive_masters();
                @(negedge clk);
                check_reset("after_abort");
                break;
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        pend_ifu = 1'b0;
        pend_lsu = 1'b0;
        last_lsu = 1'b1;
        drive_masters();
        bus.s_req_ready   = 1'b0;
        bus.s_rsp_valid   = 1'b0;
        bus.s_rdata       = '0;
        bus.ifu_rsp_ready = 1'b0;
        bus.lsu_rsp_ready = 1'b0;
        do_reset();

        // IFU read alone, immediate slave
        new_ifu(32'h8000_0000);
        run_txn(0, 0, 0, 0, 1'b0, 1'b1, 32'h0000_0413);

        // Ties after reset: IFU, then LSU, then IFU again
        do_reset();
        new_ifu($urandom);
        new_lsu($urandom, 1'b0, $urandom, 4'hF);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);
        run_txn(1, 1, 1, 0, 1'b0, 1'b0, '0);
        new_ifu($urandom);
        new_lsu($urandom, 1'b1, $urandom, 4'h3);
        run_txn(0, 1, 0, 0, 1'b0, 1'b0, '0);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);

        // LSU write returns zero data
        new_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        run_txn(0, 0, 0, 0, 1'b0, 1'b1, 32'h1234_5678);

        // Backpressure on both sides with IFU left waiting
        new_ifu($urandom);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);
        new_ifu($urandom);
        new_lsu($urandom, 1'b0, $urandom, 4'hF);
        run_txn(3, 0, 2, 0, 1'b0, 1'b0, '0);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);

        // Silent slave times out, next request is clean
        new_lsu($urandom, 1'b0, $urandom, 4'hF);
        run_txn(20, 0, 0, 0, 1'b0, 1'b0, '0);
        new_ifu($urandom);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);

        // Reset while waiting for the slave reply
        new_lsu($urandom, 1'b0, $urandom, 4'hF);
        run_txn(0, 20, 0, 2, 1'b0, 1'b0, '0);
        new_ifu($urandom);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, '0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if (!pend_ifu && !pend_lsu) begin
                case ($urandom_range(0, 2))
                    0: new_ifu($urandom);
                    1: new_lsu($urandom, 1'($urandom), $urandom, 4'($urandom));
                    default: begin
                        new_ifu($urandom);
                        new_lsu($urandom, 1'($urandom), $urandom, 4'($urandom));
                    end
                endcase
            end
            run_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)), 0, 1'b1, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_23060184_mem_arbiter.md
# ysyx_23060184_mem_arbiter

Two-master, one-slave memory arbiter that shares the single memory port between the instruction fetch path (IFU, read-only) and the load/store path (LSU, read/write). It serialises requests with round-robin tie-breaking, holds exactly one transaction in flight, and routes the response back to the granted master. A timeout returns an error response if the slave stalls. It sits between the fetch and load/store stages and the memory model / bus bridge.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles from grant to slave response before error; counter is 8 bits, legal range 1..255
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ifu_req_valid` / `ifu_req_ready`  in / out  1  IFU request handshake
- `ifu_addr`  in  ADDR_W  IFU fetch address
- `ifu_rsp_valid` / `ifu_rsp_ready`  out / in  1  IFU response handshake
- `ifu_rdata`  out  DATA_W  fetched word
- `ifu_rsp_err`  out  1  timeout error flag
- `lsu_req_valid` / `lsu_req_ready`  in / out  1  LSU request handshake
- `lsu_addr`  in  ADDR_W  LSU address
- `lsu_wen`  in  1  1 = write, 0 = read
- `lsu_wdata`  in  DATA_W  store data
- `lsu_wmask`  in  4  byte strobes
- `lsu_rsp_valid` / `lsu_rsp_ready`  out / in  1  LSU response handshake
- `lsu_rdata`  out  DATA_W  load data (0 for writes)
- `lsu_rsp_err`  out  1  timeout error flag
- `s_req_valid` / `s_req_ready`  out / in  1  slave request handshake
- `s_addr`, `s_wen`, `s_wdata`, `s_wmask`  out  ADDR_W/1/DATA_W/4  latched request
- `s_rsp_valid` / `s_rsp_ready`  in / out  1  slave response handshake
- `s_rdata`  in  DATA_W  slave read data

## Operation
- States: IDLE, REQ, WAIT, RESP. One transaction in flight at a time.
- IDLE: compute grant combinationally. Only one master valid: grant it. Both valid: grant the master not in `last_grant`. Assert `*_req_ready` only to the granted master, and only in IDLE. On handshake: latch addr, wen, wdata, wmask (IFU forces wen=0, wmask=0, wdata=0); record `gnt`; set `last_grant`=gnt; clear timer; go to REQ.
- REQ: `s_req_valid`=1 with latched fields held stable. On `s_req_ready`, go to WAIT.
- WAIT: `s_rsp_ready`=1. On `s_rsp_valid`, latch `s_rdata` (forced to 0 if the latched wen=1), err=0, go to RESP.
- Timer: increments every cycle in REQ and WAIT. When it reaches TIMEOUT with no completing handshake that cycle: go to RESP with err=1 and rdata=0; drop `s_req_valid` and `s_rsp_ready`. A handshake in the same cycle as expiry wins, with no error.
- RESP: the granted master's `*_rsp_valid`=1 with rdata and err held. The other master sees `rsp_valid`=0. On `*_rsp_ready`, go to IDLE.
- Outputs to the non-granted master stay 0. A master may drop `req_valid` before it is granted without side effects.
- After a timeout, the slave must not send a late response. Any late response is not accepted, because `s_rsp_ready`=0 outside WAIT.

## Timing
- Reset values: state=IDLE, `last_grant`=LSU (so the first tie goes to IFU), timer=0, all `*_valid`/`*_ready` outputs 0, `s_addr`/`s_wdata`/`s_wmask`/`s_wen`=0, rdata=0, err=0.
- Reset has priority over every transition; asserting it mid-transaction aborts to IDLE the next cycle with reset values.
- `*_req_ready` is combinational from state and valids; all other outputs are registered or decoded from state.
- Minimum latency, with the accept at cycle T: `s_req_valid` at T+1; with `s_req_ready`=1 at T+1 → WAIT at T+2; with `s_rsp_valid` at T+2 → `*_rsp_valid` at T+3.
- Throughput: the next accept is at the earliest one cycle after the response handshake. The IDLE bubble is mandatory, giving a minimum of 4 cycles per transaction.
- Timeout: with no slave activity, err response is asserted exactly TIMEOUT+1 cycles after the accept.

## Test plan
- IFU read alone: addr 0x8000_0000, slave ready and response immediate, rdata 0x0000_0413 → `ifu_rsp_valid` at T+3 with 0x0000_0413, err=0; LSU outputs stay 0.
- Simultaneous IFU and LSU after reset → IFU granted first; LSU granted on the next IDLE. A third tie → IFU again (alternation).
- LSU write: addr 0x8000_1000, wdata 0xDEADBEEF, wmask 0xF → `s_*` fields match and are stable through REQ; `lsu_rdata`=0, err=0.
- Backpressure: `s_req_ready` low 3 cycles, then `lsu_rsp_ready` low 2 cycles → `s_*` and rsp fields stay constant; no second grant occurs.
- Timeout with TIMEOUT=4 and a silent slave → err=1, rdata=0 at accept+5. A following IFU request then completes normally.
- Reset asserted in WAIT → next cycle all outputs at reset values; a fresh request afterward completes correctly.
